bcd_to_binary_seq: RTL and testbench
====================================

// Module: bcd_to_binary_seq
// PURPOSE
//  Sequential BCD-to-binary converter (reverse double-dabble: shift right, subtract 3).
//  Inverse of the combinational binary-to-BCD path that drives HEX0..HEX2.
//  Turns a decimal value keyed in on SW (3 BCD digits) into a binary operand
//  for the counter/adder datapath.
//  One bit per clock; start/busy/done handshake; digit and range error flags.
// PARAMETERS
//  DIGITS  3  number of BCD digits on bcd_in (4 bits each)
//  BIN_W   8  binary result width; also the number of shift iterations
// PORTS
//  clk        in   1           system clock (CLOCK_50 at top level), rising edge
//  rst        in   1           synchronous reset, active high
//  start      in   1           conversion request; sampled only in IDLE
//  bcd_in     in   4*DIGITS    packed BCD, digit 0 (ones) in [3:0]
//  busy       out  1           high in SHIFT and DONE
//  done       out  1           one-cycle pulse when result/flags valid
//  bin_out    out  BIN_W       binary result; held until next accepted start
//  err_digit  out  1           some input digit > 9; held like bin_out
//  err_ovf    out  1           BCD value > 2^BIN_W-1; held like bin_out
// BEHAVIOUR
//  - Clock/reset: single clock clk; rst synchronous, active high.
//  - Reset: state=IDLE; busy, done, bin_out, err_digit, err_ovf all 0.
//    rst mid-conversion aborts; no done pulse.
//  - States: IDLE -> SHIFT -> DONE -> IDLE; IDLE -> DONE on bad digit.
//  - IDLE, start=1:
//    - Latch bcd_in into BCD shift reg; clear the BIN_W-bit bin shift reg and iteration counter.
//    - Clear err_digit/err_ovf.
//    - Any digit > 9: err_digit=1, bin_out=0, go DONE.
//    - Otherwise go SHIFT.
//  - SHIFT, one iteration per clock, BIN_W iterations:
//    - Shift {bcd,bin} right by 1; the bcd LSB enters the bin MSB.
//    - Then for each digit: if digit >= 8, digit -= 3.
//    - Counter wraps from BIN_W-1 to DONE.
//  - DONE, one cycle:
//    - done=1.
//    - bin_out = bin reg.
//    - err_ovf = (residual bcd reg != 0).
//    - Next state IDLE.
//  - Latency: start sampled at edge N -> done high after edge N+BIN_W+1 (9 clocks default).
//    Bad-digit latency is 1 clock.
//  - start while busy=1 (SHIFT or DONE) is ignored, not queued.
//    start at the IDLE edge right after DONE is accepted: back-to-back rate is BIN_W+2 clocks.
//  - Arithmetic: bin reg always equals value mod 2^BIN_W after BIN_W shifts.
//    err_ovf is exact for any valid input.
//  - bcd_in is don't-care except on the accepting edge.
// CONFIGURATION
//  SAT_EN defined:
//    on err_ovf=1, bin_out is forced to all ones (2^BIN_W-1).
//  SAT_EN undefined:
//    bin_out = value mod 2^BIN_W (wrapped low bits); err_ovf reported identically.
//  err_digit path is unaffected by SAT_EN.
// TESTING
//  - bcd_in=12'h255, start 1 clk -> busy 9 clks, done after 9 clks, bin_out=8'hFF, errs 0.
//  - bcd_in=12'h000 -> bin_out=8'h00; bcd_in=12'h128 -> bin_out=8'h80; no errors.
//  - bcd_in=12'h999 -> err_ovf=1; bin_out=8'hE7 without SAT_EN, 8'hFF with SAT_EN.
//  - bcd_in=12'h0A5 -> done 1 clk after start, err_digit=1, bin_out=8'h00, err_ovf=0.
//  - start 12'h100, re-pulse start with 12'h077 at clk 3 -> ignored; result 8'h64 only.
//  - rst at clk 4 of a conversion -> no done, all outputs 0.
//    Next start 12'h042 -> bin_out=8'h2A.

Source files
------------

// File: rtl/bcd_to_binary_seq.sv
// Sequential BCD-to-binary converter using reverse double-dabble, one bit per clock.
// Ports: clk, rst (sync, active high), start, bcd_in -> busy, done, bin_out, err_digit, err_ovf.
// Optional macro SAT_EN: on overflow, bin_out saturates to all ones instead of wrapping.
module bcd_to_binary_seq #(
    parameter int DIGITS = 3,
    parameter int BIN_W  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [4*DIGITS-1:0]   bcd_in,
    output logic                  busy,
    output logic                  done,
    output logic [BIN_W-1:0]      bin_out,
    output logic                  err_digit,
    output logic                  err_ovf
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int CNT_W = (BIN_W > 1) ? $clog2(BIN_W) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIN_W - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [BCD_W-1:0]   bcd_q, bcd_d;
    logic [BIN_W-1:0]   bin_q, bin_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               done_q, done_d;
    logic [BIN_W-1:0]   bin_out_q, bin_out_d;
    logic               err_digit_q, err_digit_d;
    logic               err_ovf_q, err_ovf_d;

    logic               bad_digit;
    logic               ovf;
    logic [BCD_W-1:0]   bcd_shr;
    logic [BCD_W-1:0]   bcd_adj;

    // Digit validity of the incoming word.
    always_comb begin
        bad_digit = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd_in[4*i +: 4] > 4'd9) begin
                bad_digit = 1'b1;
            end
        end
    end

    // Shift right, then pull any digit that landed at >= 8 back by 3
    // (undoes the halving carry that crossed a decimal digit boundary).
    always_comb begin
        bcd_shr = bcd_q >> 1;
        bcd_adj = bcd_shr;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd_shr[4*i +: 4] >= 4'd8) begin
                bcd_adj[4*i +: 4] = bcd_shr[4*i +: 4] - 4'd3;
            end
        end
    end

    // Any BCD left after BIN_W shifts means value >= 2^BIN_W.
    assign ovf = |bcd_q;

    always_comb begin
        state_d     = state_q;
        bcd_d       = bcd_q;
        bin_d       = bin_q;
        cnt_d       = cnt_q;
        done_d      = 1'b0;
        bin_out_d   = bin_out_q;
        err_digit_d = err_digit_q;
        err_ovf_d   = err_ovf_q;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    bin_d       = '0;
                    cnt_d       = '0;
                    err_digit_d = bad_digit;
                    err_ovf_d   = 1'b0;
                    if (bad_digit) begin
                        // Zeroed registers make DONE report 0 with no overflow.
                        bcd_d   = '0;
                        state_d = S_DONE;
                    end else begin
                        bcd_d   = bcd_in;
                        state_d = S_SHIFT;
                    end
                end
            end
            S_SHIFT: begin
                bcd_d = bcd_adj;
                bin_d = {bcd_q[0], bin_q[BIN_W-1:1]};
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_DONE: begin
                done_d    = 1'b1;
                err_ovf_d = ovf;
`ifdef SAT_EN
                bin_out_d = ovf ? {BIN_W{1'b1}} : bin_q;
`else
                bin_out_d = bin_q;
`endif
                state_d   = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            bcd_q       <= '0;
            bin_q       <= '0;
            cnt_q       <= '0;
            done_q      <= 1'b0;
            bin_out_q   <= '0;
            err_digit_q <= 1'b0;
            err_ovf_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            bcd_q       <= bcd_d;
            bin_q       <= bin_d;
            cnt_q       <= cnt_d;
            done_q      <= done_d;
            bin_out_q   <= bin_out_d;
            err_digit_q <= err_digit_d;
            err_ovf_q   <= err_ovf_d;
        end
    end

    assign busy      = (state_q != S_IDLE);
    assign done      = done_q;
    assign bin_out   = bin_out_q;
    assign err_digit = err_digit_q;
    assign err_ovf   = err_ovf_q;

endmodule

// File: tb/tb_bcd_to_binary_seq.sv
// Scoreboard testbench for bcd_to_binary_seq: directed cases plus random BCD words.
// Expected results come from a decimal-arithmetic model; a monitor checks each done pulse.
module tb_bcd_to_binary_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [11:0] bcd_in;
    logic        busy;
    logic        done;
    logic [7:0]  bin_out;
    logic        err_digit;
    logic        err_ovf;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        logic [7:0] bin;
        bit         dig;
        bit         ovf;
        int         done_cyc;
        logic [11:0] src;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    bcd_to_binary_seq #(.DIGITS(3), .BIN_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .bcd_in    (bcd_in),
        .busy      (busy),
        .done      (done),
        .bin_out   (bin_out),
        .err_digit (err_digit),
        .err_ovf   (err_ovf)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Decimal reference: value = 100*h + 10*t + o, result wraps or saturates.
    function automatic exp_t model(input logic [11:0] b, input int acc);
        exp_t e;
        int d0, d1, d2, v;
        d0 = int'(b[3:0]);
        d1 = int'(b[7:4]);
        d2 = int'(b[11:8]);
        e.src = b;
        if (d0 > 9 || d1 > 9 || d2 > 9) begin
            e.bin      = 8'd0;
            e.dig      = 1'b1;
            e.ovf      = 1'b0;
            e.done_cyc = acc + 1;
        end else begin
            v     = d2 * 100 + d1 * 10 + d0;
            e.dig = 1'b0;
            e.ovf = (v > 255);
`ifdef SAT_EN
            e.bin = e.ovf ? 8'hFF : 8'(v);
`else
            e.bin = 8'(v % 256);
`endif
            e.done_cyc = acc + 9;
        end
        return e;
    endfunction

    always @(negedge clk) begin
        if (done) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done=1 expected no pending result (t=%0t)", $time);
            end else begin
                mon_e = sb.pop_front();
                chk($sformatf("bin_out[%h]", mon_e.src), int'(bin_out), int'(mon_e.bin));
                chk($sformatf("err_digit[%h]", mon_e.src), int'(err_digit), int'(mon_e.dig));
                chk($sformatf("err_ovf[%h]", mon_e.src), int'(err_ovf), int'(mon_e.ovf));
                chk($sformatf("latency[%h]", mon_e.src), cyc, mon_e.done_cyc);
            end
        end
    end

    // Called at a negedge; the following posedge is the accepting edge.
    task automatic issue(input logic [11:0] b, input bit push);
        exp_t e;
        bcd_in = b;
        start  = 1'b1;
        if (push) begin
            e = model(b, cyc + 1);
            sb.push_back(e);
        end
        @(negedge clk);
        start  = 1'b0;
        bcd_in = 12'($urandom);
        chk("busy_after_start", int'(busy), 1);
    endtask

    task automatic wait_done();
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done) return;
        end
        checks++;
        errors++;
        $display("FAIL done_timeout: got no done expected done within 40 cycles");
    endtask

    function automatic logic [11:0] rand_bcd();
        logic [11:0] b;
        for (int i = 0; i < 3; i++) begin
            if ($urandom_range(0, 9) == 0) b[4*i +: 4] = 4'($urandom_range(0, 15));
            else b[4*i +: 4] = 4'($urandom_range(0, 9));
        end
        return b;
    endfunction

    initial begin
        rst    = 1'b1;
        start  = 1'b0;
        bcd_in = 12'h000;
        repeat (3) @(negedge clk);
        chk("reset_busy", int'(busy), 0);
        chk("reset_done", int'(done), 0);
        chk("reset_bin_out", int'(bin_out), 0);
        chk("reset_err_digit", int'(err_digit), 0);
        chk("reset_err_ovf", int'(err_ovf), 0);
        rst = 1'b0;
        @(negedge clk);

        issue(12'h255, 1'b1); wait_done();
        issue(12'h000, 1'b1); wait_done();
        issue(12'h128, 1'b1); wait_done();
        issue(12'h999, 1'b1); wait_done();
        issue(12'h0A5, 1'b1); wait_done();
        issue(12'h256, 1'b1); wait_done();
        issue(12'h9F0, 1'b1); wait_done();

        // A start while busy is dropped.
        issue(12'h100, 1'b1);
        @(negedge clk);
        bcd_in = 12'h077;
        start  = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        wait_done();

        // Reset mid-conversion: no result, outputs cleared.
        issue(12'h555, 1'b0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_busy", int'(busy), 0);
        chk("abort_done", int'(done), 0);
        chk("abort_bin_out", int'(bin_out), 0);
        chk("abort_err_digit", int'(err_digit), 0);
        chk("abort_err_ovf", int'(err_ovf), 0);
        repeat (12) @(negedge clk);
        issue(12'h042, 1'b1); wait_done();

        for (int n = 0; n < 40; n++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            issue(rand_bcd(), 1'b1);
            wait_done();
        end

        repeat (4) @(negedge clk);
        chk("scoreboard_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
